// File: rtl/register_bank_multiport_pkg.sv
// Shared constants, FSM encoding and packed-bus slice helpers for the
// multiport register bank.
package register_bank_multiport_pkg;

  localparam int RB_DATA_WIDTH = 64;
  localparam int RB_ADDR_WIDTH = 5;
  localparam int RB_ZERO_REG   = 31;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } rb_state_e;

  // LSB of port k inside a packed address bus
  function automatic int unsigned addr_lsb(input int unsigned port, input int unsigned aw);
    return port * aw;
  endfunction

  // LSB of port k inside a packed data bus
  function automatic int unsigned data_lsb(input int unsigned port, input int unsigned dw);
    return port * dw;
  endfunction

endpackage

// File: rtl/register_bank_multiport_read_port.sv
// One combinational read port: busy mask, hardwired zero register,
// optional same-cycle write bypass, then the array mux.
module register_read_port
  import register_bank_multiport_pkg::*;
#(
  parameter int DATA_WIDTH = RB_DATA_WIDTH,
  parameter int ADDR_WIDTH = RB_ADDR_WIDTH,
  parameter int ZERO_REG   = RB_ZERO_REG,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                                          busy_i,
  input  logic [ADDR_WIDTH-1:0]                         rd_addr_i,
  input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]    array_i,
  input  logic                                          wr_en_i,
  input  logic [ADDR_WIDTH-1:0]                         wr_addr_i,
  input  logic [DATA_WIDTH-1:0]                         wr_data_i,
  output logic [DATA_WIDTH-1:0]                         rd_data_o
);

  logic is_zero;
  logic hit;

  assign is_zero = (rd_addr_i == ADDR_WIDTH'(ZERO_REG));
  assign hit     = BYPASS && wr_en_i && (wr_addr_i == rd_addr_i);

  // Priority: busy, then zero register, then bypass, then stored value
  always_comb begin
    rd_data_o = '0;
    if (busy_i || is_zero) begin
      rd_data_o = '0;
    end else if (hit) begin
      rd_data_o = wr_data_i;
    end else begin
      rd_data_o = array_i[rd_addr_i];
    end
  end

endmodule

// File: rtl/register_bank_multiport.sv
// Single-write, N-read register bank with a zero register, optional
// write bypass and a sequential clear engine driven after reset/clear.
module register_bank_multiport
  import register_bank_multiport_pkg::*;
#(
  parameter int DATA_WIDTH = RB_DATA_WIDTH,
  parameter int ADDR_WIDTH = RB_ADDR_WIDTH,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = RB_ZERO_REG,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             clear_i,
  input  logic                             write_i,
  input  logic [ADDR_WIDTH-1:0]            write_address_i,
  input  logic [DATA_WIDTH-1:0]            write_data_i,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address_i,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data_o,
  output logic                             busy_o,
  output logic                             write_dropped_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ZR       = ADDR_WIDTH'(ZERO_REG);

  rb_state_e                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]              clr_idx_q, clr_idx_d;
  logic                               wdrop_q, wdrop_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]   array_q;

  logic                               arr_we;
  logic [ADDR_WIDTH-1:0]              arr_addr;
  logic [DATA_WIDTH-1:0]              arr_wdata;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    arr_we    = 1'b0;
    arr_addr  = write_address_i;
    arr_wdata = write_data_i;
    wdrop_d   = write_i && ((state_q == ST_CLEARING) || (write_address_i == ZR) || clear_i);
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d   = ST_CLEARING;
          clr_idx_d = '0;
        end else if (write_i && (write_address_i != ZR)) begin
          arr_we = 1'b1;
        end
      end
      ST_CLEARING: begin
        arr_we    = 1'b1;
        arr_addr  = clr_idx_q;
        arr_wdata = '0;
        if (clear_i) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_CLEARING;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_CLEARING;
      clr_idx_q <= '0;
      wdrop_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wdrop_q   <= wdrop_d;
    end
  end

  // Storage has no reset; the clear engine is what zeroes it
  always_ff @(posedge clock_i) begin
    if (!reset_i && arr_we) begin
      array_q[arr_addr] <= arr_wdata;
    end
  end

  assign busy_o          = (state_q == ST_CLEARING);
  assign write_dropped_o = wdrop_q;

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rp
    register_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_rp (
      .busy_i    (busy_o),
      .rd_addr_i (read_address_i[addr_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH]),
      .array_i   (array_q),
      .wr_en_i   (write_i),
      .wr_addr_i (write_address_i),
      .wr_data_i (write_data_i),
      .rd_data_o (read_data_o[data_lsb(k, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_register_bank_multiport.sv
// Directed bench: a 4-port bypassing bank and a 2-port non-bypassing bank
// share one stimulus stream; expectations go through a scoreboard queue.
module tb_register_bank_multiport;

  logic          clk = 1'b0;
  logic          rst, clr, wr;
  logic [4:0]    waddr;
  logic [63:0]   wdata;
  logic [19:0]   raddr;
  logic [255:0]  rdata_a;
  logic [127:0]  rdata_b;
  logic          busy_a, busy_b, wdrop_a, wdrop_b;

  typedef struct { string tag; logic [63:0] val; } exp_t;
  exp_t sb[$];
  int   total = 0;
  int   fails = 0;
  int   n;

  localparam logic [63:0] V5 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] V7 = 64'hDEAD_BEEF_0000_0001;

  always #5 clk = ~clk;

  register_bank_multiport #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .READ_PORTS(4),
                            .ZERO_REG(31), .BYPASS(1'b1)) dut_a (
    .clock_i(clk), .reset_i(rst), .clear_i(clr), .write_i(wr),
    .write_address_i(waddr), .write_data_i(wdata), .read_address_i(raddr),
    .read_data_o(rdata_a), .busy_o(busy_a), .write_dropped_o(wdrop_a));

  register_bank_multiport #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .READ_PORTS(2),
                            .ZERO_REG(31), .BYPASS(1'b0)) dut_b (
    .clock_i(clk), .reset_i(rst), .clear_i(clr), .write_i(wr),
    .write_address_i(waddr), .write_data_i(wdata), .read_address_i(raddr[9:0]),
    .read_data_o(rdata_b), .busy_o(busy_b), .write_dropped_o(wdrop_b));

  function automatic logic [63:0] pa(input int k);
    return rdata_a[k*64 +: 64];
  endfunction
  function automatic logic [63:0] pb(input int k);
    return rdata_b[k*64 +: 64];
  endfunction

  task automatic setra(input int k, input logic [4:0] a);
    raddr[k*5 +: 5] = a;
  endtask

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic expv(input string tag, input logic [63:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: got %h expected nothing", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    cyc();
    rst = 1'b0;
    #1;
    expv("reset_busy_a", 64'd1);   chk({63'd0, busy_a});
    expv("reset_busy_b", 64'd1);   chk({63'd0, busy_b});
    expv("reset_wdrop", 64'd0);    chk({63'd0, wdrop_a});
    expv("busy_read_mask", 64'd0); chk(pa(0));
    n = 1;
    for (int i = 0; i < 100; i++) begin
      cyc(); #1;
      if (busy_a) n++; else break;
    end
    expv("reset_clear_len", 64'd32); chk(64'(n));

    for (int i = 0; i < 32; i++) begin
      setra(0, 5'(i)); setra(1, 5'(i));
      #1;
      expv("post_clear_a0", 64'd0); chk(pa(0));
      expv("post_clear_a1", 64'd0); chk(pa(1));
      expv("post_clear_b0", 64'd0); chk(pb(0));
      expv("post_clear_b1", 64'd0); chk(pb(1));
    end

    // X5 write, same-cycle read: bypass on A, old value on B
    cyc();
    wr = 1'b1; waddr = 5'd5; wdata = V5; setra(0, 5'd5); setra(1, 5'd5);
    #1;
    expv("x5_bypass_a0", V5);  chk(pa(0));
    expv("x5_bypass_a1", V5);  chk(pa(1));
    expv("x5_nobyp_b0", 64'd0); chk(pb(0));
    expv("x5_nobyp_b1", 64'd0); chk(pb(1));
    cyc();
    wr = 1'b0;
    #1;
    expv("x5_read_a0", V5); chk(pa(0));
    expv("x5_read_a1", V5); chk(pa(1));
    expv("x5_read_b0", V5); chk(pb(0));
    expv("x5_read_b1", V5); chk(pb(1));
    expv("x5_wdrop", 64'd0); chk({63'd0, wdrop_a});

    cyc();
    wr = 1'b1; waddr = 5'd7; wdata = V7; setra(0, 5'd7);
    #1;
    expv("x7_bypass_a0", V7);   chk(pa(0));
    expv("x7_nobyp_b0", 64'd0); chk(pb(0));
    expv("x7_other_b1", V5);    chk(pb(1));
    cyc();
    wr = 1'b0;
    #1;
    expv("x7_read_a0", V7); chk(pa(0));
    expv("x7_read_b0", V7); chk(pb(0));

    // Zero register: writes discarded and flagged, never bypassed
    cyc();
    wr = 1'b1; waddr = 5'd31; wdata = '1; setra(0, 5'd31);
    #1;
    expv("x31_same_a0", 64'd0); chk(pa(0));
    expv("x31_same_b0", 64'd0); chk(pb(0));
    cyc();
    wr = 1'b0;
    #1;
    expv("x31_wdrop_a", 64'd1); chk({63'd0, wdrop_a});
    expv("x31_wdrop_b", 64'd1); chk({63'd0, wdrop_b});
    expv("x31_read_a0", 64'd0); chk(pa(0));
    expv("x31_read_b0", 64'd0); chk(pb(0));
    cyc(); #1;
    expv("wdrop_pulse_end", 64'd0); chk({63'd0, wdrop_a});

    cyc(); wr = 1'b1; waddr = 5'd1; wdata = 64'd11;
    cyc(); wr = 1'b1; waddr = 5'd2; wdata = 64'd22;
    cyc(); wr = 1'b0;
    setra(0, 5'd1); setra(1, 5'd2); setra(2, 5'd31); setra(3, 5'd1);
    #1;
    expv("p4_a0", 64'd11); chk(pa(0));
    expv("p4_a1", 64'd22); chk(pa(1));
    expv("p4_a2", 64'd0);  chk(pa(2));
    expv("p4_a3", 64'd11); chk(pa(3));
    expv("p4_b0", 64'd11); chk(pb(0));
    expv("p4_b1", 64'd22); chk(pb(1));

    // Clear with a simultaneous write: clear wins, write flagged
    cyc();
    clr = 1'b1; wr = 1'b1; waddr = 5'd4; wdata = 64'd44;
    cyc();
    clr = 1'b0; wr = 1'b1; waddr = 5'd3; wdata = 64'd9; setra(0, 5'd3);
    #1;
    expv("clr_wr_wdrop", 64'd1); chk({63'd0, wdrop_a});
    expv("clr_busy", 64'd1);     chk({63'd0, busy_a});
    expv("busy_no_bypass", 64'd0); chk(pa(0));
    cyc();
    wr = 1'b0;
    #1;
    expv("busy_wr_wdrop", 64'd1); chk({63'd0, wdrop_a});
    cyc(); #1;
    expv("busy_wdrop_end", 64'd0); chk({63'd0, wdrop_a});
    for (int i = 0; i < 8; i++) cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    #1;
    n = busy_a ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_a) break;
      cyc(); #1;
      if (busy_a) n++;
    end
    expv("restart_clear_len", 64'd32); chk(64'(n));
    setra(0, 5'd3); setra(1, 5'd1); setra(2, 5'd5); setra(3, 5'd2);
    #1;
    expv("x3_after_clear", 64'd0); chk(pa(0));
    expv("x1_after_clear", 64'd0); chk(pa(1));
    expv("x5_after_clear", 64'd0); chk(pa(2));
    expv("x2_after_clear", 64'd0); chk(pa(3));
    expv("idle_after_clear", 64'd0); chk({63'd0, busy_a});

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
